// File: rtl/cpu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq
//  Purpose  : Multi-T-state CPU sequencer. Every state lasts whole M-cycles
//             of T_PER_M T-states each. Supports a small opcode subset:
//             NOP, HALT, DI, EI, JP nn and JR e. Memory wait states stretch
//             the last T-state of a memory M-cycle.
//  Ports    : i_clk, i_rst (sync, active high)
//             i_mem_rd_data, i_mem_ready       - memory read data / ready
//             o_mem_rd_en, o_mem_rd_addr       - read strobe / address
//             o_mem_wr_en, o_mem_wr_addr,
//             o_mem_wr_data                    - write strobe / addr / data
//             i_irq, o_irq_ack                 - interrupt request / ack
//             o_halted, o_pc, o_m_end          - status
//  Config   : define CPU_SEQ_IRQ_EN to build the interrupt entry sequence,
//             IME and DI/EI. Without it i_irq only wakes HALT.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_seq #(
    parameter int          T_PER_M    = 4,
    parameter logic [15:0] RESET_PC   = 16'h0100,
    parameter logic [15:0] RESET_SP   = 16'hFFFE,
    parameter logic [15:0] IRQ_VECTOR = 16'h0040
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_mem_rd_data,
    input  logic        i_mem_ready,
    output logic        o_mem_rd_en,
    output logic [15:0] o_mem_rd_addr,
    output logic        o_mem_wr_en,
    output logic [15:0] o_mem_wr_addr,
    output logic [7:0]  o_mem_wr_data,
    input  logic        i_irq,
    output logic        o_irq_ack,
    output logic        o_halted,
    output logic [15:0] o_pc,
    output logic        o_m_end
);

    localparam logic [2:0] c_t_last   = 3'(T_PER_M - 1);
    localparam logic [7:0] c_op_jp    = 8'hC3;
    localparam logic [7:0] c_op_jr    = 8'h18;
    localparam logic [7:0] c_op_halt  = 8'h76;
`ifdef CPU_SEQ_IRQ_EN
    localparam logic [7:0] c_op_di    = 8'hF3;
    localparam logic [7:0] c_op_ei    = 8'hFB;
`endif

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_OPERAND = 3'd1,
        S_EXEC    = 3'd2,
        S_HALT    = 3'd3
`ifdef CPU_SEQ_IRQ_EN
        , S_IRQ   = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_boundary_next;
    logic [2:0]  r_t;
    logic [2:0]  r_m;          // M-cycle index within the current state
    logic [15:0] r_pc;
    logic [7:0]  r_ir;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
`ifdef CPU_SEQ_IRQ_EN
    logic [15:0] r_sp;
    logic        r_ime;
    logic        r_ei_pend;    // EI seen; IME rises after the next FETCH
    logic        w_ime_now;
`endif

    logic        w_last;
    logic        w_m_end;
    logic        w_rd_en;
    logic [15:0] w_rd_addr;
    logic        w_wr_en;
    logic [15:0] w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        w_irq_ack;
    logic        w_halted;

    assign w_last = (r_t == c_t_last);

    // ------------------------------------------------------------------
    // Next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_rd_en   = 1'b0;
        w_rd_addr = 16'h0000;
        w_wr_en   = 1'b0;
        w_wr_addr = 16'h0000;
        w_wr_data = 8'h00;
        w_irq_ack = 1'b0;
        w_halted  = 1'b0;
        w_m_end   = 1'b0;

        // Where an instruction goes once its final M-cycle completes.
`ifdef CPU_SEQ_IRQ_EN
        // A DI being fetched right now must already block the request.
        w_ime_now = ((r_state == S_FETCH) && (i_mem_rd_data == c_op_di))
                    ? 1'b0 : (r_ime | r_ei_pend);
        w_boundary_next = (i_irq && w_ime_now) ? S_IRQ : S_FETCH;
`else
        w_boundary_next = S_FETCH;
`endif

        case (r_state)
            S_FETCH, S_OPERAND: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_pc;
            end
            S_HALT: w_halted = 1'b1;
`ifdef CPU_SEQ_IRQ_EN
            S_IRQ: begin
                w_irq_ack = (r_m == 3'd0) && (r_t == 3'd0);
                if (r_m == 3'd2) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_sp - 16'd1;
                    w_wr_data = r_pc[15:8];
                end else if (r_m == 3'd3) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_sp - 16'd2;
                    w_wr_data = r_pc[7:0];
                end
            end
`endif
            default: ;
        endcase

        // Internal M-cycles ignore i_mem_ready.
        w_m_end = w_last && (i_mem_ready || !(w_rd_en || w_wr_en));

        if (w_m_end) begin
            case (r_state)
                S_FETCH: begin
                    case (i_mem_rd_data)
                        c_op_jp, c_op_jr: w_next = S_OPERAND;
                        c_op_halt:        w_next = S_HALT;
                        default:          w_next = w_boundary_next;
                    endcase
                end
                S_OPERAND: begin
                    if ((r_ir == c_op_jp) && (r_m == 3'd0))
                        w_next = S_OPERAND;
                    else
                        w_next = S_EXEC;
                end
                S_EXEC: w_next = w_boundary_next;
                S_HALT: if (i_irq) w_next = w_boundary_next;
`ifdef CPU_SEQ_IRQ_EN
                S_IRQ:  if (r_m == 3'd4) w_next = S_FETCH;
`endif
                default: w_next = S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // T/M counters and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_t  <= 3'd0;
            r_m  <= 3'd0;
            r_pc <= RESET_PC;
            r_ir <= 8'h00;
            r_lo <= 8'h00;
            r_hi <= 8'h00;
`ifdef CPU_SEQ_IRQ_EN
            r_sp      <= RESET_SP;
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
`endif
        end else begin
            // T holds at its last value while a wait state is inserted.
            if (w_m_end)      r_t <= 3'd0;
            else if (!w_last) r_t <= r_t + 3'd1;

            if (w_m_end) begin
                r_m <= (w_next != r_state) ? 3'd0 : r_m + 3'd1;
                case (r_state)
                    S_FETCH: begin
                        r_ir <= i_mem_rd_data;
                        r_pc <= r_pc + 16'd1;
`ifdef CPU_SEQ_IRQ_EN
                        if (i_mem_rd_data == c_op_di) begin
                            r_ime     <= 1'b0;
                            r_ei_pend <= 1'b0;
                        end else begin
                            if (r_ei_pend) r_ime <= 1'b1;
                            r_ei_pend <= (i_mem_rd_data == c_op_ei);
                        end
`endif
                    end
                    S_OPERAND: begin
                        if (r_m == 3'd0) r_lo <= i_mem_rd_data;
                        else             r_hi <= i_mem_rd_data;
                        r_pc <= r_pc + 16'd1;
                    end
                    S_EXEC: begin
                        if (r_ir == c_op_jp) r_pc <= {r_hi, r_lo};
                        else                 r_pc <= r_pc + {{8{r_lo[7]}}, r_lo};
                    end
`ifdef CPU_SEQ_IRQ_EN
                    S_IRQ: begin
                        if (r_m == 3'd4) begin
                            r_pc  <= IRQ_VECTOR;
                            r_sp  <= r_sp - 16'd2;
                            r_ime <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifndef CPU_SEQ_IRQ_EN
    // Stack and vector parameters only matter when interrupt entry exists.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{RESET_SP, IRQ_VECTOR};
`endif

    // Reset forces every bus output quiet in the same cycle.
    assign o_mem_rd_en   = w_rd_en & ~i_rst;
    assign o_mem_rd_addr = i_rst ? 16'h0000 : w_rd_addr;
    assign o_mem_wr_en   = w_wr_en & ~i_rst;
    assign o_mem_wr_addr = i_rst ? 16'h0000 : w_wr_addr;
    assign o_mem_wr_data = i_rst ? 8'h00 : w_wr_data;
    assign o_irq_ack     = w_irq_ack & ~i_rst;
    assign o_halted      = w_halted & ~i_rst;
    assign o_m_end       = w_m_end & ~i_rst;
    assign o_pc          = r_pc;

endmodule
`default_nettype wire

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter T_PER_M, default 4, T-states per M-cycle; legal range 2..8.
REQ-002 Parameter RESET_PC, default 16'h0100, PC value after reset.
REQ-003 Parameter RESET_SP, default 16'hFFFE, SP value after reset.
REQ-004 Parameter IRQ_VECTOR, default 16'h0040, interrupt entry address.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_mem_rd_data  in  8  read data, sampled on the last T-state of a read M-cycle.
REQ-008 i_mem_ready  in  1  memory ready; low on the last T-state inserts a wait state.
REQ-009 o_mem_rd_en  out  1  read strobe, high for every T-state of a read M-cycle.
REQ-010 o_mem_rd_addr  out  16  read address, stable for the whole M-cycle.
REQ-011 o_mem_wr_en  out  1  write strobe, high for every T-state of a write M-cycle.
REQ-012 o_mem_wr_addr  out  16  write address.
REQ-013 o_mem_wr_data  out  8  write data, 8'h00 when o_mem_wr_en is low.
REQ-014 i_irq  in  1  level interrupt request.
REQ-015 o_irq_ack  out  1  one-cycle pulse on the first T-state of interrupt entry.
REQ-016 o_halted  out  1  high while in HALT state.
REQ-017 o_pc  out  16  current PC.
REQ-018 o_m_end  out  1  one-cycle pulse on the completing T-state of every M-cycle.

Function
REQ-019 States: FETCH, OPERAND, EXEC, HALT, IRQ; every state lasts a whole number of M-cycles.
REQ-020 T counter runs 0..T_PER_M-1; M-cycle completes at T=T_PER_M-1 with i_mem_ready high (always high for internal cycles); otherwise T holds at T_PER_M-1.
REQ-021 FETCH: one read M-cycle at PC; on completion IR <= data, PC <= PC+1 (16-bit wrap, FFFF->0000).
REQ-022 Opcodes: 00 NOP (1 M total), 76 HALT (1 M), F3 DI (1 M), FB EI (1 M, IME set after following instruction's FETCH), C3 JP nn (4 M), 18 JR e (3 M); all other opcodes execute as NOP.
REQ-023 JP nn: OPERAND reads lo then hi at PC, PC+1 each; one internal EXEC M-cycle; PC <= {hi,lo}.
REQ-024 JR e: OPERAND reads e; internal EXEC M-cycle; PC <= PC + sign-extended e, modulo 2^16.
REQ-025 After final M-cycle of an instruction: IRQ if i_irq and IME, else FETCH.
REQ-026 HALT: no memory strobes; exits to FETCH (IME=0) or IRQ (IME=1) the M-cycle boundary after i_irq is high.
REQ-027 IRQ: 5 M-cycles; M1-M2 internal; M3 write PC[15:8] at SP-1; M4 write PC[7:0] at SP-2; M5 internal, PC <= IRQ_VECTOR, SP <= SP-2, IME <= 0.
REQ-028 i_irq sampled only at instruction boundaries; a request deasserting mid-instruction is ignored.
REQ-029 o_mem_rd_en and o_mem_wr_en never high in the same cycle.

Reset
REQ-030 While i_rst high at a clock edge: state FETCH, T=0, PC=RESET_PC, SP=RESET_SP, IR=00, IME=0, all strobes/pulses 0, addresses 16'h0000, o_mem_wr_data 8'h00, o_halted 0.
REQ-031 Reset mid-instruction or mid-wait-state abandons it; first FETCH read at RESET_PC begins the cycle after i_rst falls.

Configuration
REQ-032 Macro CPU_SEQ_IRQ_EN defined: IRQ state, IME, DI/EI, o_irq_ack behaviour as above.
REQ-033 Macro undefined: IRQ state absent, i_irq only wakes HALT to FETCH, DI/EI execute as NOP, o_irq_ack tied 0.

Verification
REQ-034 Reset, mem 0100=00, 0101=00, T_PER_M=4 -> reads at 0100 and 0101 each 4 cycles long, o_m_end every 4th cycle.
REQ-035 0100=C3,34,12 -> reads 0100,0101,0102, one internal M-cycle, next fetch at 1234, 16 cycles total.
REQ-036 0100=18,FE -> JR -2 returns to 0100; fetch repeats at 0100 every 12 cycles.
REQ-037 i_mem_ready low 3 cycles during first fetch -> that M-cycle lasts 7 cycles, IR and PC correct.
REQ-038 With CPU_SEQ_IRQ_EN: FB,00,76, raise i_irq in HALT -> o_irq_ack pulse, writes 01@FFFD then 03@FFFC, next fetch at 0040, SP=FFFC.
REQ-039 Assert i_rst during JP operand read -> next read at 0100, no write strobes.
